// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice resolved per stage,
// slice carry and unprocessed operand bits forwarded in registers, valid/ready stream handshake.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned SL = WIDTH / STAGES;
  localparam int unsigned NG = SL / 4;

  logic             advance_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             c0_c;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q, zero_q, neg_q;

  // Whole pipeline moves together; a held result stalls every stage.
  assign advance_c = !out_valid_q || out_ready;
  assign in_ready  = advance_c && !rst;
  assign b_eff_c   = sub ? ~b : b;
  assign c0_c      = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO = k * SL;
    localparam int unsigned HI = LO + SL;
    localparam int unsigned YW = WIDTH - LO;

    logic [WIDTH-1:0] x_in;
    logic [YW-1:0]    y_in;
    logic             c_in;
    logic             v_in;
    logic [SL-1:0]    g, p, sum_c;
    logic [SL:0]      cb;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      cg;

    // x carries finished sum bits below LO and operand A at/above LO; y holds remaining B bits.
    if (k == 0) begin : g_src
      assign x_in = a;
      assign y_in = b_eff_c;
      assign c_in = c0_c;
      assign v_in = in_valid;
    end else begin : g_prev
      assign x_in = g_stg[k-1].g_mid.x_q;
      assign y_in = g_stg[k-1].g_mid.y_q;
      assign c_in = g_stg[k-1].g_mid.c_q;
      assign v_in = g_stg[k-1].g_mid.v_q;
    end

    assign g = x_in[HI-1:LO] & y_in[SL-1:0];
    assign p = x_in[HI-1:LO] ^ y_in[SL-1:0];

    // Group generate/propagate, flat lookahead across groups, then flat lookahead within each group.
    always_comb begin
      logic term;
      logic prod;
      gg   = '0;
      gp   = '0;
      cg   = '0;
      cb   = '0;
      term = 1'b0;
      prod = 1'b1;
      for (int j = 0; j < NG; j++) begin
        gg[j] = g[4*j+3]
              | (p[4*j+3] & g[4*j+2])
              | (p[4*j+3] & p[4*j+2] & g[4*j+1])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        gp[j] = &p[4*j +: 4];
      end
      cg[0] = c_in;
      for (int j = 1; j < NG + 1; j++) begin
        term = 1'b0;
        prod = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          term = term | (gg[i] & prod);
          prod = prod & gp[i];
        end
        cg[j] = term | (prod & c_in);
      end
      for (int j = 0; j < NG; j++) begin
        cb[4*j]   = cg[j];
        cb[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
        cb[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
        cb[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
      end
      cb[SL] = cg[NG];
    end

    assign sum_c = p ^ cb[SL-1:0];

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0]    x_q, x_d;
      logic [WIDTH-HI-1:0] y_q;
      logic                c_q;
      logic                v_q;

      always_comb begin
        x_d         = x_in;
        x_d[HI-1:LO] = sum_c;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          x_q <= '0;
          y_q <= '0;
          c_q <= 1'b0;
        end else if (advance_c) begin
          v_q <= v_in;
          x_q <= x_d;
          y_q <= y_in[YW-1:SL];
          c_q <= cb[SL];
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] s_d;

      always_comb begin
        s_d         = x_in;
        s_d[HI-1:LO] = sum_c;
      end

      // Final stage registers the result and flags; ovf from carries into/out of the MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          s_q         <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
          zero_q      <= 1'b0;
          neg_q       <= 1'b0;
        end else if (advance_c) begin
          out_valid_q <= v_in;
          s_q         <= s_d;
          cout_q      <= cb[SL];
          ovf_q       <= cb[SL] ^ cb[SL-1];
          zero_q      <= (s_d == '0);
          neg_q       <= s_d[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 32-bit single-cycle fast adder. The operand width is split into STAGES equal slices. Each slice is resolved by 4-bit lookahead groups in its own register stage, and the slice carry ripples stage-to-stage through registers. The block adds a subtract mode, status flags and a valid/ready stream interface so it can sit between the operand register file and the ALU result mux in pipelined datapaths.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4*STAGES.
STAGES, 2, number of register stages (1..WIDTH/4); equals latency in cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operands on a/b/cin/sub are valid.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in (borrow-in when sub=1, see Behaviour).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result/flags valid.
out_ready  input  1  downstream accepts result.
s  output  WIDTH  sum/difference.
cout  output  1  carry out of MSB.
ovf  output  1  signed two's-complement overflow.
zero  output  1  s == 0.
neg  output  1  s[WIDTH-1].

Behaviour:
- Reset: synchronous, highest priority. Clears all stage valid bits, out_valid, s, cout, ovf, zero, neg to 0, and flushes in-flight data. in_ready = 0 while rst = 1.
- Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Stall: advance = !out_valid || out_ready, and in_ready = advance && !rst (combinational). The pipeline moves as one unit. Bubbles are not collapsed.
- While advance = 0, all stage registers and outputs hold. s and the flags stay stable while out_valid = 1 and out_ready = 0.
- Latency: exactly STAGES cycles from the accepting edge to out_valid, given no stall. Throughput is 1 per cycle with out_ready held high. Order is preserved.
- Operand conditioning at acceptance:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- Stage k (0..STAGES-1) computes slice bits [(k+1)*SL-1 : k*SL], where SL = WIDTH/STAGES.
  - Slice inputs are the registered carry from stage k-1 (c0 for k=0) and the registered remaining operand slices.
  - Per-bit generate g = a&b_eff and propagate p = a^b_eff.
  - 4-bit group lookahead inside each slice; group carries are formed by lookahead over groups, not ripple through bits.
  - Lower result bits and the unprocessed upper operand bits are forwarded in registers. Only the needed bits are registered.
- Outputs (final stage):
  - cout = carry out of bit WIDTH-1, raw. In subtract mode cout=1 means no borrow.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (s == 0).
  - neg = s[WIDTH-1].
- STAGES=1 degenerates to a single registered CLA with latency 1.
- Boundary cases:
  - Simultaneous accept and drain in the same cycle is legal when the pipeline is full and out_ready = 1.
  - Wrap-around is modulo 2^WIDTH.
  - Inputs are ignored when in_valid = 0; a bubble propagates with valid = 0 and its data is don't-care.
  - Reset mid-operation drops all in-flight results; no partial result ever appears on out_valid.

Test Plan:
1. WIDTH=32, STAGES=2: accept a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0 -> 2 cycles later out_valid=1, s=0, cout=1, zero=1, ovf=0, neg=0.
2. a=0x0000_FFFF, b=0x0000_0001, add -> s=0x0001_0000, cout=0 (carry crosses stage boundary). Then a=0x7FFF_FFFF, b=1 -> s=0x8000_0000, ovf=1, neg=1, cout=0.
3. Subtract: a=0x8000_0000, b=1, sub=1, cin=0 -> s=0x7FFF_FFFF, ovf=1, cout=1. Then a=5, b=5, sub=1, cin=1 -> s=0xFFFF_FFFF, cout=0, neg=1.
4. Stream 4 back-to-back ops with out_ready=1 -> 4 consecutive out_valid cycles starting at cycle 2, results in input order.
5. Fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0, s and flags stable, no loss or duplication after out_ready returns to 1.
6. Assert rst for one cycle with 2 ops in flight -> next cycle out_valid=0 and all outputs 0. The in-flight results never appear; a new op accepted after reset completes with latency 2.
